// File: rtl/avr_pmem_pkg.sv
// Shared definitions for the AVR program-memory port controller.
package avr_pmem_pkg;

    localparam int PMEM_AW_DEFAULT = 9;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LPM_RET = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RESTART = 2'd3
    } pmem_state_e;

    // Which requester's read is outstanding (data returns next cycle)
    localparam logic [1:0] REQ_NONE  = 2'd0;
    localparam logic [1:0] REQ_FETCH = 2'd1;
    localparam logic [1:0] REQ_LPM   = 2'd2;
    localparam logic [1:0] REQ_LOAD  = 2'd3;

endpackage

// File: rtl/avr_pmem_arb.sv
// Program-memory port controller: shares one synchronous-read, single-port
// program memory between instruction fetch, LPM byte reads and the loader.
//
// state      | meaning
// -----------+----------------------------------------------------------
// RUN        | fetch owns the port; LPM may preempt for one cycle
// LPM_RET    | LPM data returns and is acked; fetch granted again
// LOAD       | loader owns the port, core held
// RESTART    | one idle cycle after the loader releases the memory
module avr_pmem_arb
    import avr_pmem_pkg::*;
#(
    parameter int AW = PMEM_AW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          f_req,
    input  logic [15:0]   f_addr,
    output logic [15:0]   f_data,
    output logic          f_valid,
    output logic          f_stall,
    input  logic          lpm_req,
    input  logic [15:0]   lpm_z,
    output logic [7:0]    lpm_data,
    output logic          lpm_ack,
    input  logic          ld_en,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_wdata,
    output logic [15:0]   ld_rdata,
    output logic          cpu_hold,
    output logic [AW-1:0] m_addr,
    output logic          m_rd,
    output logic          m_we,
    output logic [15:0]   m_wdata,
    input  logic [15:0]   m_rdata
);

    pmem_state_e state_q, state_d;
    logic [1:0]  rd_type_q, rd_type_d;
    logic        z0_q, z0_d;
    logic [7:0]  lpm_data_q;
    logic [15:0] ld_rdata_q;
    logic [7:0]  lpm_byte;

    // Address bits above the memory size simply wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[15:AW], lpm_z[15:AW+1]};

    // Port arbitration, qualifiers and next-state selection
    always_comb begin
        state_d   = state_q;
        rd_type_d = REQ_NONE;
        z0_d      = z0_q;
        m_addr    = f_addr[AW-1:0];
        m_rd      = 1'b0;
        m_we      = 1'b0;
        m_wdata   = ld_wdata;
        f_stall   = 1'b1;
        cpu_hold  = 1'b0;
        if (!RST) begin
            unique case (state_q)
                ST_RUN, ST_LPM_RET: begin
                    if (ld_en) begin
                        cpu_hold = 1'b1;
                        state_d  = ST_LOAD;
                    end else if (state_q == ST_RUN && lpm_req) begin
                        // LPM steals exactly this one fetch slot
                        m_addr    = lpm_z[AW:1];
                        m_rd      = 1'b1;
                        z0_d      = lpm_z[0];
                        rd_type_d = REQ_LPM;
                        state_d   = ST_LPM_RET;
                    end else begin
                        f_stall   = 1'b0;
                        m_rd      = f_req;
                        rd_type_d = f_req ? REQ_FETCH : REQ_NONE;
                        state_d   = ST_RUN;
                    end
                end
                ST_LOAD: begin
                    cpu_hold = 1'b1;
                    if (ld_en) begin
                        m_addr    = ld_addr;
                        m_we      = ld_we;
                        m_rd      = !ld_we;
                        rd_type_d = ld_we ? REQ_NONE : REQ_LOAD;
                    end else begin
                        state_d = ST_RESTART;
                    end
                end
                ST_RESTART: begin
                    cpu_hold = 1'b1;
                    state_d  = ld_en ? ST_LOAD : ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State, outstanding-read tag and held read-back values
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_RUN;
            rd_type_q  <= REQ_NONE;
            z0_q       <= 1'b0;
            lpm_data_q <= 8'h00;
            ld_rdata_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            rd_type_q  <= rd_type_d;
            z0_q       <= z0_d;
            lpm_data_q <= lpm_data;
            ld_rdata_q <= ld_rdata;
        end
    end

    assign lpm_byte = z0_q ? m_rdata[15:8] : m_rdata[7:0];

    // Read data is live in its return cycle, then held for late consumers.
    assign lpm_data = (rd_type_q == REQ_LPM)  ? lpm_byte : lpm_data_q;
    assign ld_rdata = (rd_type_q == REQ_LOAD) ? m_rdata  : ld_rdata_q;
    assign lpm_ack  = (state_q == ST_LPM_RET);
    assign f_valid  = (rd_type_q == REQ_FETCH);
    assign f_data   = m_rdata;

endmodule
